// File: rtl/gray_track_pkg.sv
// Shared types and defaults for the Gray-count tracker: FSM states, delta classes
// and the delta classifier.
package gray_track_pkg;

  localparam int W_DEF    = 2;
  localparam int PW_DEF   = 16;
  localparam int ERRW_DEF = 8;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    UP      = 2'd1,
    DN      = 2'd2,
    ILLEGAL = 2'd3
  } delta_t;

  // A modular delta of all-ones (-1 mod 2^w) is a legal down-step.
  function automatic delta_t classify(input logic [31:0] delta, input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    if (delta == 32'd0) begin
      return HOLD;
    end else if (delta == 32'd1) begin
      return UP;
    end else if (delta == mask) begin
      return DN;
    end else begin
      return ILLEGAL;
    end
  endfunction

endpackage

// File: rtl/gray2bin_dec.sv
// Combinational W-bit Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above it.
module gray2bin_dec #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  logic w_acc;

  // Running XOR from the MSB down.
  always_comb begin
    o_bin = '0;
    w_acc = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      w_acc    = w_acc ^ i_gray[i];
      o_bin[i] = w_acc;
    end
  end

endmodule

// File: rtl/gray_count_tracker.sv
// Gray-count receiver: decodes, classifies steps, accumulates position and tracks
// illegal jumps. Define GRAY_TRACK_SYNC_EN to add 2-flop input synchronizers.
module gray_count_tracker
  import gray_track_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int PW   = PW_DEF,
  parameter int ERRW = ERRW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [W-1:0]    gray_in,
  input  logic            clr_err,
  output logic [W-1:0]    bin_out,
  output logic [PW-1:0]   pos,
  output logic            step_up,
  output logic            step_dn,
  output logic            locked,
  output logic            err,
  output logic [ERRW-1:0] err_cnt
);

  logic [W-1:0]    w_gray;
  logic            w_ena;
  logic [W-1:0]    w_bin;
  logic [W-1:0]    w_delta;
  delta_t          w_cls;
  logic            w_illegal;
  logic [ERRW-1:0] w_err_inc;

  state_t          r_state;
  logic [W-1:0]    r_bin_prev;
  logic [W-1:0]    r_bin_out;
  logic [PW-1:0]   r_pos;
  logic            r_step_up;
  logic            r_step_dn;
  logic            r_locked;
  logic            r_err;
  logic [ERRW-1:0] r_err_cnt;

`ifdef GRAY_TRACK_SYNC_EN
  logic [W-1:0] r_gray_s1;
  logic [W-1:0] r_gray_s2;
  logic         r_ena_s1;
  logic         r_ena_s2;

  // Two-flop synchronizers for a source in another clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gray_s1 <= '0;
      r_gray_s2 <= '0;
      r_ena_s1  <= 1'b0;
      r_ena_s2  <= 1'b0;
    end else begin
      r_gray_s1 <= gray_in;
      r_gray_s2 <= r_gray_s1;
      r_ena_s1  <= ena;
      r_ena_s2  <= r_ena_s1;
    end
  end

  assign w_gray = r_gray_s2;
  assign w_ena  = r_ena_s2;
`else
  assign w_gray = gray_in;
  assign w_ena  = ena;
`endif

  gray2bin_dec #(.W(W)) u_dec (
    .i_gray (w_gray),
    .o_bin  (w_bin)
  );

  // Step classification against the last accepted sample; counter saturates.
  always_comb begin
    w_delta   = w_bin - r_bin_prev;
    w_cls     = classify(32'(w_delta), W);
    w_illegal = w_ena && (w_cls == ILLEGAL);
    if (r_err_cnt == {ERRW{1'b1}}) begin
      w_err_inc = r_err_cnt;
    end else begin
      w_err_inc = r_err_cnt + ERRW'(1);
    end
  end

  // Lock FSM with position accumulator, error counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ACQ;
      r_bin_prev <= '0;
      r_bin_out  <= '0;
      r_pos      <= '0;
      r_step_up  <= 1'b0;
      r_step_dn  <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_step_up <= 1'b0;
      r_step_dn <= 1'b0;
      case (r_state)
        ACQ: begin
          if (clr_err) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
          end
          if (w_ena) begin
            r_bin_prev <= w_bin;
            r_bin_out  <= w_bin;
            r_locked   <= 1'b1;
            r_state    <= TRACK;
          end
        end
        TRACK: begin
          if (w_ena) begin
            r_bin_prev <= w_bin;
            r_bin_out  <= w_bin;
          end
          // An illegal sample beats a concurrent clear: count restarts at 1.
          if (w_illegal) begin
            r_err     <= 1'b1;
            r_err_cnt <= clr_err ? ERRW'(1) : w_err_inc;
            r_locked  <= 1'b0;
            r_state   <= FAULT;
          end else begin
            if (clr_err) begin
              r_err     <= 1'b0;
              r_err_cnt <= '0;
            end
            if (w_ena && (w_cls == UP)) begin
              r_pos     <= r_pos + PW'(1);
              r_step_up <= 1'b1;
            end else if (w_ena && (w_cls == DN)) begin
              r_pos     <= r_pos - PW'(1);
              r_step_dn <= 1'b1;
            end
          end
        end
        FAULT: begin
          if (clr_err) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_state   <= ACQ;
            if (w_ena) begin
              r_bin_out <= w_bin;
            end
          end else if (w_ena) begin
            r_bin_prev <= w_bin;
            r_bin_out  <= w_bin;
            if (w_illegal) begin
              r_err_cnt <= w_err_inc;
            end
          end
        end
        default: begin
          r_state  <= ACQ;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bin_out = r_bin_out;
  assign pos     = r_pos;
  assign step_up = r_step_up;
  assign step_dn = r_step_dn;
  assign locked  = r_locked;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_gray_count_tracker.sv
// Bench for gray_count_tracker: vector table through a scoreboard queue, plus
// hand-written latency and mid-run reset sequences. A second DUT uses ERRW=2.
module tb_gray_count_tracker;

`ifdef GRAY_TRACK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [1:0]  gray_in = 2'b00;
  logic        clr_err = 1'b0;

  logic [1:0]  bin_out;
  logic [15:0] pos;
  logic        step_up, step_dn, locked, err;
  logic [7:0]  err_cnt;

  logic [1:0]  e2_bin_out;
  logic [15:0] e2_pos;
  logic        e2_step_up, e2_step_dn, e2_locked, e2_err;
  logic [1:0]  e2_err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_count_tracker dut (
    .clk(clk), .rst(rst), .ena(ena), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(bin_out), .pos(pos), .step_up(step_up), .step_dn(step_dn),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  gray_count_tracker #(.W(2), .PW(16), .ERRW(2)) dut_e2 (
    .clk(clk), .rst(rst), .ena(ena), .gray_in(gray_in), .clr_err(clr_err),
    .bin_out(e2_bin_out), .pos(e2_pos), .step_up(e2_step_up), .step_dn(e2_step_dn),
    .locked(e2_locked), .err(e2_err), .err_cnt(e2_err_cnt)
  );

  typedef struct {
    logic        rst;
    logic        ena;
    logic        clr;
    logic [1:0]  g;
    logic [1:0]  bin;
    logic [15:0] pos;
    logic        up;
    logic        dn;
    logic        lk;
    logic        er;
    logic [7:0]  ec;
    logic [1:0]  ec2;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic c, input logic [1:0] g,
                     input logic [1:0] b, input logic [15:0] p, input logic u, input logic d,
                     input logic l, input logic er, input logic [7:0] ec, input logic [1:0] ec2);
    vec_t v;
    v.rst = r; v.ena = e; v.clr = c; v.g = g; v.bin = b; v.pos = p; v.up = u; v.dn = d;
    v.lk = l; v.er = er; v.ec = ec; v.ec2 = ec2;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t exp;
    int   edges;
    logic [1:0] seq [6];
    seq[0] = 2'b11; seq[1] = 2'b10; seq[2] = 2'b00;
    seq[3] = 2'b01; seq[4] = 2'b11; seq[5] = 2'b10;

    //   rst   ena   clr   gray    bin    pos        up    dn    lk    err   ec     ec2
    add(1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b01, 2'd1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b11, 2'd2, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b10, 2'd3, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b01, 2'd1, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b0, 1'b0, 2'b11, 2'd1, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b1, 1'b0, 1'b0, 2'b00, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b10, 2'd3, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b11, 2'd2, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1);
    add(1'b0, 1'b1, 1'b0, 2'b11, 2'd2, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 2'd2);
    add(1'b0, 1'b0, 1'b1, 2'b11, 2'd2, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b01, 2'd1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b11, 2'd2, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1);
    add(1'b0, 1'b1, 1'b0, 2'b11, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 2'd2);
    add(1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 2'd3);
    add(1'b0, 1'b1, 1'b0, 2'b11, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 2'd3);
    add(1'b0, 1'b1, 1'b0, 2'b10, 2'd3, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 2'd3);
    add(1'b0, 1'b1, 1'b1, 2'b11, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b11, 2'd2, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b1, 2'b00, 2'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'd1);
    add(1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b0, 2'b01, 2'd1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
    add(1'b0, 1'b1, 1'b1, 2'b11, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);

`ifndef GRAY_TRACK_SYNC_EN
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; ena = tbl[i].ena; clr_err = tbl[i].clr; gray_in = tbl[i].g;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      chk($sformatf("v%0d_bin", i), 32'(bin_out), 32'(exp.bin));
      chk($sformatf("v%0d_pos", i), 32'(pos), 32'(exp.pos));
      chk($sformatf("v%0d_up", i), 32'(step_up), 32'(exp.up));
      chk($sformatf("v%0d_dn", i), 32'(step_dn), 32'(exp.dn));
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(exp.lk));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(exp.er));
      chk($sformatf("v%0d_errcnt", i), 32'(err_cnt), 32'(exp.ec));
      chk($sformatf("v%0d_errcnt_sat", i), 32'(e2_err_cnt), 32'(exp.ec2));
    end
`endif

    // Step-up latency from the edge that samples it, then climb to pos=7.
    @(negedge clk);
    rst = 1'b1; ena = 1'b0; clr_err = 1'b0; gray_in = 2'b00;
    @(negedge clk);
    rst = 1'b0; ena = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    chk("relock", 32'(locked), 32'd1);
    gray_in = 2'b01;
    edges = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (step_up) break;
    end
    chk("up_latency", 32'(edges), 32'(LAT));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      gray_in = seq[k];
    end
    repeat (LAT + 1) @(negedge clk);
    chk("pos_at_7", 32'(pos), 32'd7);
    chk("locked_at_7", 32'(locked), 32'd1);

    // Asynchronous reset away from any clock edge.
    rst = 1'b1;
    #1;
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_flags", {28'd0, step_up, step_dn, err, e2_err}, 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0; ena = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
